// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM encodings and divider helper
// Purpose: common definitions imported by uart_core and uart_baud_gen.
// Ports: none (package).
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Oversample divider, rounded to nearest and never below one clock.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick generator
// Purpose: one-clock tick pulse every DIV clocks.
// Ports: clk, reset (async active-low), tick (output pulse).
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 UART transmitter and 16x oversampling receiver
// Purpose: independent TX and RX paths sharing one clock.
// Ports: clk, reset (async active-low); tx_start, tx_data in; tx_status, tx_end, txd out;
//        rxd in; rx_data, rx_end, rx_ferr out.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_status,
  output logic       tx_end,
  output logic       txd,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_end,
  output logic       rx_ferr
);

  localparam int DIV        = calc_div(CLK_FREQ, BAUD);
  localparam int BIT_CYCLES = OVERSAMPLE * DIV;
  localparam int TCW        = $clog2(BIT_CYCLES);
  localparam logic [TCW-1:0] TX_LAST  = TCW'(BIT_CYCLES - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [3:0]     HALF_TCK = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     FULL_TCK = 4'(OVERSAMPLE - 1);

  // ---------------- transmitter ----------------
  tx_state_t      tx_state, tx_state_n;
  logic [TCW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]     tx_bit, tx_bit_n;
  logic [7:0]     tx_shift, tx_shift_n;
  logic           txd_n, tx_end_n, tx_wrap;

  assign tx_wrap   = (tx_cnt == TX_LAST);
  assign tx_status = (tx_state == TX_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tx_end   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
      tx_end   <= tx_end_n;
    end
  end

  // txd is registered; the next-state logic loads the level of the bit being entered.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_wrap ? '0 : tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tx_end_n   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        txd_n    = 1'b1;
        if (tx_start) begin
          tx_state_n = TX_START;
          tx_shift_n = tx_data;
          tx_bit_n   = '0;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_wrap) begin
          tx_state_n = TX_DATA;
          txd_n      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_wrap) begin
          if (tx_bit == LAST_BIT) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = tx_shift >> 1;
            txd_n      = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_wrap) begin
          tx_state_n = TX_IDLE;
          tx_end_n   = 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2, rx_prev, rx_fall, rx_tick;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (rx_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_tcnt, rx_tcnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n, rx_data_n;
  logic       rx_end_n, rx_ferr_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_end   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      rx_end   <= rx_end_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  // rx_tcnt counts ticks already seen in the current bit; the Nth tick arrives at N-1.
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    rx_end_n   = 1'b0;
    rx_ferr_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_tcnt_n  = '0;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_tcnt_n = rx_tcnt + 1'b1;
          if (rx_tcnt == HALF_TCK) begin
            rx_tcnt_n  = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_tcnt_n = rx_tcnt + 1'b1;
          if (rx_tcnt == FULL_TCK) begin
            rx_tcnt_n  = '0;
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
            else rx_bit_n = rx_bit + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_tcnt_n = rx_tcnt + 1'b1;
          if (rx_tcnt == FULL_TCK) begin
            rx_tcnt_n = '0;
            if (rx_s2) begin
              rx_data_n  = rx_shift;
              rx_end_n   = 1'b1;
              rx_state_n = RX_IDLE;
            end else begin
              rx_ferr_n  = 1'b1;
              rx_state_n = RX_WAIT_HIGH;
            end
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - self-checking bench for uart_core against a frame-level model
module tb_uart_core;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BITC     = 160;
  localparam int FRAME    = 10 * BITC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_status, tx_end, txd;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_end, rx_ferr;

  logic loop = 1'b0;
  logic rxd_drv = 1'b1;
  assign rxd = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_status (tx_status),
    .tx_end    (tx_end),
    .txd       (txd),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_end    (rx_end),
    .rx_ferr   (rx_ferr)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: bytes expected on rx_end in order, last good byte.
  logic [7:0] expq[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] mon_exp;
  int n_tx_end = 0, n_rx_end = 0, n_ferr = 0, n_wide = 0;
  logic p_tx_end = 1'b0, p_rx_end = 1'b0, p_ferr = 1'b0;

  always @(negedge clk) begin
    if (tx_end) n_tx_end++;
    if (rx_ferr) n_ferr++;
    if ((tx_end && p_tx_end) || (rx_end && p_rx_end) || (rx_ferr && p_ferr)) n_wide++;
    p_tx_end = tx_end;
    p_rx_end = rx_end;
    p_ferr   = rx_ferr;
    if (rx_end) begin
      n_rx_end++;
      if (expq.size() == 0) begin
        check("rx_unexpected_frame", 32'd1, 32'd0);
      end else begin
        mon_exp = expq.pop_front();
        last_good = mon_exp;
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
      end
    end
  end

  // Sends one frame and compares every cycle with the ideal 8N1 waveform:
  // after the acceptance edge c=0, the line carries frame bit c/BITC until c=FRAME.
  task automatic send_frame(input logic [7:0] d, input bit pre, input int ign_at,
                            input logic [7:0] ign_d, input bit chain, input logic [7:0] chain_d,
                            input int abort_at, input string tag);
    logic [9:0] fr;
    int wave_bad, ctl_bad;
    logic exp_txd, exp_done;
    fr = {1'b1, d, 1'b0};
    wave_bad = 0;
    ctl_bad = 0;
    if (!pre) begin
      check({tag, "_ready"}, {31'd0, tx_status}, 32'd1);
      tx_data = d;
      tx_start = 1'b1;
    end
    for (int c = 0; c <= FRAME; c++) begin
      @(posedge clk);
      @(negedge clk);
      tx_start = 1'b0;
      exp_done = (c == FRAME);
      exp_txd  = exp_done ? 1'b1 : fr[c / BITC];
      if (c == 0) check({tag, "_start_low"}, {31'd0, txd}, 32'd0);
      if (txd !== exp_txd) wave_bad++;
      if (tx_end !== exp_done || tx_status !== exp_done) ctl_bad++;
      if (c == abort_at) begin
        check({tag, "_wave_pre"}, wave_bad, 0);
        reset = 1'b0;
        #1;
        check({tag, "_rst_txd"}, {31'd0, txd}, 32'd1);
        check({tag, "_rst_status"}, {31'd0, tx_status}, 32'd1);
        check({tag, "_rst_tx_end"}, {31'd0, tx_end}, 32'd0);
        return;
      end
      if (c == ign_at) begin
        tx_data = ign_d;
        tx_start = 1'b1;
      end
      if (chain && exp_done) begin
        tx_data = chain_d;
        tx_start = 1'b1;
      end
    end
    check({tag, "_wave"}, wave_bad, 0);
    check({tag, "_ctl"}, ctl_bad, 0);
  endtask

  task automatic rx_bits(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (BITC) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  int t0, r0, f0, quiet_bad;
  logic [7:0] b;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_status", {31'd0, tx_status}, 32'd1);
    check("rst_tx_end", {31'd0, tx_end}, 32'd0);
    check("rst_rx_end", {31'd0, rx_end}, 32'd0);
    check("rst_ferr", {31'd0, rx_ferr}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 0xA5
    loop = 1'b1;
    t0 = n_tx_end; r0 = n_rx_end;
    expq.push_back(8'hA5);
    send_frame(8'hA5, 0, -1, 8'h00, 0, 8'h00, -1, "a5");
    repeat (20) @(negedge clk);
    check("a5_tx_end_cnt", n_tx_end - t0, 1);
    check("a5_rx_end_cnt", n_rx_end - r0, 1);
    check("a5_rx_data", {24'd0, rx_data}, 32'hA5);

    // Request during a frame is ignored
    t0 = n_tx_end; r0 = n_rx_end;
    expq.push_back(8'hA5);
    send_frame(8'hA5, 0, 400, 8'h3C, 0, 8'h00, -1, "ign");
    quiet_bad = 0;
    repeat (FRAME + 100) begin
      @(negedge clk);
      if (!tx_status || !txd) quiet_bad++;
    end
    check("ign_idle_after", quiet_bad, 0);
    check("ign_tx_end_cnt", n_tx_end - t0, 1);
    check("ign_rx_end_cnt", n_rx_end - r0, 1);

    // False start
    loop = 1'b0;
    r0 = n_rx_end; f0 = n_ferr;
    rxd_drv = 1'b0;
    repeat (30) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("fs_rx_end_cnt", n_rx_end - r0, 0);
    check("fs_ferr_cnt", n_ferr - f0, 0);

    // Framing error then valid frame
    r0 = n_rx_end; f0 = n_ferr;
    rx_bits(8'h5A, 1'b0);
    repeat (100) @(negedge clk);
    check("fe_ferr_cnt", n_ferr - f0, 1);
    check("fe_rx_end_cnt", n_rx_end - r0, 0);
    check("fe_rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
    expq.push_back(8'h11);
    rx_bits(8'h11, 1'b1);
    repeat (50) @(negedge clk);
    check("fe_next_rx_end_cnt", n_rx_end - r0, 1);
    check("fe_next_rx_data", {24'd0, rx_data}, 32'h11);
    check("fe_ferr_cnt_after", n_ferr - f0, 1);

    // Random bit-banged frames with random phase
    r0 = n_rx_end;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      expq.push_back(b);
      rx_bits(b, 1'b1);
    end
    repeat (50) @(negedge clk);
    check("rnd_rx_end_cnt", n_rx_end - r0, 3);

    // Back-to-back 0xFF then 0x01
    loop = 1'b1;
    repeat (20) @(negedge clk);
    t0 = n_tx_end; r0 = n_rx_end;
    expq.push_back(8'hFF);
    expq.push_back(8'h01);
    send_frame(8'hFF, 0, -1, 8'h00, 1, 8'h01, -1, "ff");
    send_frame(8'h01, 1, -1, 8'h00, 0, 8'h00, -1, "c01");
    repeat (20) @(negedge clk);
    check("b2b_tx_end_cnt", n_tx_end - t0, 2);
    check("b2b_rx_end_cnt", n_rx_end - r0, 2);
    check("b2b_rx_data", {24'd0, rx_data}, 32'h01);

    // Random loopback frames
    t0 = n_tx_end; r0 = n_rx_end;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      expq.push_back(b);
      send_frame(b, 0, -1, 8'h00, 0, 8'h00, -1, "rlb");
    end
    repeat (20) @(negedge clk);
    check("rlb_tx_end_cnt", n_tx_end - t0, 3);
    check("rlb_rx_end_cnt", n_rx_end - r0, 3);

    // Reset in the middle of a frame
    t0 = n_tx_end; r0 = n_rx_end; f0 = n_ferr;
    b = 8'($urandom);
    send_frame(b, 0, -1, 8'h00, 0, 8'h00, 700, "rst");
    repeat (5) @(negedge clk);
    check("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
    last_good = 8'h00;
    reset = 1'b1;
    quiet_bad = 0;
    repeat (FRAME + 200) begin
      @(negedge clk);
      if (!tx_status || !txd) quiet_bad++;
    end
    check("rst_quiet", quiet_bad, 0);
    check("rst_tx_end_cnt", n_tx_end - t0, 0);
    check("rst_rx_end_cnt", n_rx_end - r0, 0);
    check("rst_ferr_cnt", n_ferr - f0, 0);

    check("pulse_width", n_wide, 0);
    check("rx_queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, line bit rate in bit/s.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_start  input  1  one-cycle request to send tx_data.
REQ-006 tx_data  input  8  byte to send; sampled only in the cycle tx_start is accepted.
REQ-007 tx_status  output  1  1 = transmitter idle and able to accept, 0 = busy.
REQ-008 tx_end  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-009 txd  output  1  serial line out, idle high.
REQ-010 rxd  input  1  serial line in, asynchronous to clk.
REQ-011 rx_data  output  8  last correctly framed received byte.
REQ-012 rx_end  output  1  one-cycle pulse when rx_data is updated.
REQ-013 rx_ferr  output  1  one-cycle pulse on a framing error (stop bit sampled low).

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-015 DIV = round(CLK_FREQ/(16*BAUD)), minimum 1; BIT_CYCLES = 16*DIV.
REQ-016 TX FSM states SHALL be IDLE, START, DATA, STOP; tx_status = 1 exactly while in IDLE.
REQ-017 tx_start in IDLE SHALL latch tx_data, clear the cycle counter and enter START at that edge; txd low from the next cycle.
REQ-018 tx_start outside IDLE SHALL be ignored with no effect on the frame in progress.
REQ-019 Each TX bit SHALL hold txd for exactly BIT_CYCLES clocks, counted by a TX-local counter, not the baud tick.
REQ-020 After STOP completes (10*BIT_CYCLES after acceptance), the FSM SHALL enter IDLE and tx_end SHALL be 1 for that one cycle.
REQ-021 tx_start in the tx_end cycle SHALL be accepted (state is IDLE), giving back-to-back frames with no idle gap.
REQ-022 rxd SHALL pass a 2-flop synchronizer before any use.
REQ-023 RX SHALL use a free-running 16x oversample tick, one clk-cycle pulse every DIV clocks.
REQ-024 RX FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-025 IDLE -> START on a synchronized high-to-low transition; START samples at the 8th tick; low -> DATA, high -> IDLE (false start, no outputs).
REQ-026 DATA SHALL sample every 16 ticks after the mid-start sample, shifting 8 bits LSB first.
REQ-027 STOP samples 16 ticks after bit 7: high -> rx_data updated and rx_end pulsed in the same cycle, -> IDLE; low -> rx_ferr pulsed, rx_data unchanged, -> WAIT_HIGH.
REQ-028 WAIT_HIGH -> IDLE when the synchronized line is high; no new frame is started in between.
REQ-029 rx_data SHALL hold its value until the next valid frame; TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-030 Reset SHALL force txd=1, tx_status=1, tx_end=0, rx_end=0, rx_ferr=0, rx_data=0x00, both FSMs to IDLE, all counters and the synchronizer to their idle values (synchronizer flops = 1).
REQ-031 Reset mid-frame SHALL abort immediately, with no tx_end, rx_end or rx_ferr pulse on release.

Structure
REQ-032 A shared package uart_pkg SHALL hold the TX/RX state encodings and frame constants (DATA_BITS=8, OVERSAMPLE=16).
REQ-033 The oversample tick generator SHALL be a sub-module uart_baud_gen (parameter DIV, outputs tick).

Verification (bench params CLK_FREQ=1600000, BAUD=10000 -> DIV=10, BIT_CYCLES=160)
REQ-034 Loopback txd->rxd, tx_start with 0xA5 -> txd low next cycle, tx_end single pulse 1600 cycles after acceptance, rx_data=0xA5 with single rx_end pulse.
REQ-035 tx_start with 0x3C at cycle 400 of a 0xA5 frame -> ignored; only 0xA5 on the line, one tx_end.
REQ-036 rxd low for 30 cycles, then high -> no rx_end, no rx_ferr, RX back in IDLE.
REQ-037 Frame 0x5A driven with a low stop bit -> rx_ferr single pulse, rx_data keeps the previous value, next valid 0x11 frame received after the line returns high.
REQ-038 Reset asserted at cycle 700 of a TX frame -> txd=1, tx_status=1 immediately, no tx_end after release.
REQ-039 tx_start with 0x01 in the tx_end cycle of a 0xFF frame -> start bit begins the next cycle, loopback yields rx_data 0xFF then 0x01.
